// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, write-FSM states and the
// byte-strobe merge used when committing a write.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_COMMIT,
    WR_RESP
  } wr_state_e;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_STRB_W = MAX_DATA_W / 8;

  // Sized for the widest supported bus; narrower callers zero-extend.
  function automatic logic [MAX_DATA_W-1:0] strb_merge(
    input logic [MAX_DATA_W-1:0] old_v,
    input logic [MAX_DATA_W-1:0] new_v,
    input logic [MAX_STRB_W-1:0] strb
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_v;
    for (int b = 0; b < MAX_STRB_W; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_hold_buf.sv
// One-entry holding register for an AXI channel; ready is registered and is
// withheld while full or while the owner signals a stall for the next cycle.
module axi_lite_hold_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         clr,
  input  logic         stall_nxt,
  output logic         full,
  output logic [W-1:0] out_data
);

  logic         full_q, full_d;
  logic         ready_q, ready_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clr) full_d = 1'b0;
    if (in_valid && ready_q) begin
      full_d = 1'b1;
      data_d = in_data;
    end
    ready_d = !full_d && !stall_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= '0;
    end else begin
      full_q  <= full_d;
      ready_q <= ready_d;
      data_q  <= data_d;
    end
  end

  assign in_ready = ready_q;
  assign full     = full_q;
  assign out_data = data_q;

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register-bank slave: independent AW/W capture, strobed commits,
// read-only status registers and back-pressured B/R responses.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int                  ADDR_W   = 32,
  parameter int                  DATA_W   = 32,
  parameter int                  NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_W-1:0]            s_awaddr,
  input  logic [2:0]                   s_awprot,
  input  logic                         s_awvalid,
  output logic                         s_awready,
  input  logic [DATA_W-1:0]            s_wdata,
  input  logic [DATA_W/8-1:0]          s_wstrb,
  input  logic                         s_wvalid,
  output logic                         s_wready,
  output logic [1:0]                   s_bresp,
  output logic                         s_bvalid,
  input  logic                         s_bready,
  input  logic [ADDR_W-1:0]            s_araddr,
  input  logic [2:0]                   s_arprot,
  input  logic                         s_arvalid,
  output logic                         s_arready,
  output logic [DATA_W-1:0]            s_rdata,
  output logic [1:0]                   s_rresp,
  output logic                         s_rvalid,
  input  logic                         s_rready,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          reg_wr_pulse,
  input  logic [NUM_REGS*DATA_W-1:0]   status_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - OFF_W;

  wr_state_e                          state_q, state_d;
  logic                               bvalid_q, bvalid_d;
  axi_resp_e                          bresp_q, bresp_d;
  logic [NUM_REGS-1:0]                pulse_q, pulse_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]    regs_q, regs_d;

  logic                               aw_full, w_full, aw_hs, w_hs, commit;
  logic [ADDR_W-1:0]                  aw_addr;
  logic [DATA_W-1:0]                  w_data;
  logic [STRB_W-1:0]                  w_strb;

  assign aw_hs  = s_awvalid && s_awready;
  assign w_hs   = s_wvalid && s_wready;
  assign commit = (state_q == WR_COMMIT);

  axi_lite_hold_buf #(.W(ADDR_W)) u_aw_buf (
    .clk(clk), .rst_n(rst_n), .in_data(s_awaddr), .in_valid(s_awvalid),
    .in_ready(s_awready), .clr(commit), .stall_nxt(bvalid_d),
    .full(aw_full), .out_data(aw_addr)
  );

  axi_lite_hold_buf #(.W(DATA_W + STRB_W)) u_w_buf (
    .clk(clk), .rst_n(rst_n), .in_data({s_wstrb, s_wdata}), .in_valid(s_wvalid),
    .in_ready(s_wready), .clr(commit), .stall_nxt(bvalid_d),
    .full(w_full), .out_data({w_strb, w_data})
  );

  logic aw_have, w_have;
  assign aw_have = aw_full || aw_hs;
  assign w_have  = w_full || w_hs;

  always_comb begin
    state_d = state_q;
    case (state_q)
      WR_COMMIT: state_d = WR_RESP;
      WR_RESP:   if (s_bready) state_d = WR_IDLE;
      default: begin
        if (aw_have && w_have) state_d = WR_COMMIT;
        else if (aw_have)      state_d = WR_HAVE_AW;
        else if (w_have)       state_d = WR_HAVE_W;
        else                   state_d = WR_IDLE;
      end
    endcase
    bvalid_d = (state_d == WR_RESP);
  end

  logic [IDX_W-1:0]      wr_idx;
  logic                  wr_in_range, wr_ro;
  logic [DATA_W-1:0]     wr_cur;
  logic [MAX_DATA_W-1:0] old_w, new_w, merged_w;
  logic [MAX_STRB_W-1:0] strb_w;

  assign wr_idx      = aw_addr[ADDR_W-1:OFF_W];
  assign wr_in_range = wr_idx < IDX_W'(NUM_REGS);

  always_comb begin
    wr_ro  = 1'b0;
    wr_cur = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_idx == IDX_W'(i)) begin
        wr_ro  = RO_MASK[i];
        wr_cur = regs_q[i];
      end
    end
    old_w = '0;
    new_w = '0;
    strb_w = '0;
    old_w[DATA_W-1:0]  = wr_cur;
    new_w[DATA_W-1:0]  = w_data;
    strb_w[STRB_W-1:0] = w_strb;
    merged_w = strb_merge(old_w, new_w, strb_w);
  end

  always_comb begin
    regs_d  = regs_q;
    pulse_d = '0;
    bresp_d = bresp_q;
    if (commit) begin
      if (wr_in_range && !wr_ro) begin
        bresp_d = OKAY;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (wr_idx == IDX_W'(i)) begin
            regs_d[i]  = merged_w[DATA_W-1:0];
            pulse_d[i] = 1'b1;
          end
        end
      end else begin
        bresp_d = SLVERR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= WR_IDLE;
      bvalid_q <= 1'b0;
      bresp_q  <= OKAY;
      pulse_q  <= '0;
      regs_q   <= '0;
    end else begin
      state_q  <= state_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      pulse_q  <= pulse_d;
      regs_q   <= regs_d;
    end
  end

  // Read path: arready is the registered complement of the next rvalid.
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d, rd_sel;
  axi_resp_e             rresp_q, rresp_d;
  logic [IDX_W-1:0]      rd_idx;
  logic                  ar_hs;

  assign rd_idx = s_araddr[ADDR_W-1:OFF_W];
  assign ar_hs  = s_arvalid && arready_q;

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i))
        rd_sel = RO_MASK[i] ? status_i[i*DATA_W +: DATA_W] : regs_q[i];
    end
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && s_rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      if (rd_idx < IDX_W'(NUM_REGS)) begin
        rdata_d = rd_sel;
        rresp_d = OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = SLVERR;
      end
    end
    arready_d = !rvalid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_bvalid     = bvalid_q;
  assign s_bresp      = bresp_q;
  assign s_arready    = arready_q;
  assign s_rvalid     = rvalid_q;
  assign s_rdata      = rdata_q;
  assign s_rresp      = rresp_q;
  assign reg_q        = regs_q;
  assign reg_wr_pulse = pulse_q;

  logic unused_ok;
  assign unused_ok = ^{s_awprot, s_arprot, s_araddr[OFF_W-1:0], aw_addr[OFF_W-1:0], merged_w};

endmodule
